// File: rtl/prv32_muldiv_pkg.sv
// rtl/prv32_muldiv_pkg.sv - shared op codes, FSM encoding and constants for prv32_muldiv
//
// Purpose: funct3 op codes, 2-bit FSM state encoding and the XLEN_MIN_INT /
//          ALL_ONES constants used by the multiply/divide unit.
// Ports:   none (package).
package prv32_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [31:0] XLEN_MIN_INT = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/prv32_muldiv_step.sv
// rtl/prv32_muldiv_step.sv - one shift-add / restoring-divide iteration
//
// Purpose: combinational single-bit step on the 2W-bit accumulator.
//   mul (mode=0): acc = {partial_hi, multiplier}; add operand when acc[0], shift right.
//   div (mode=1): acc = {remainder, dividend/quotient}; shift left, trial subtract.
// Ports:
//   acc      in  2W  current accumulator
//   operand  in  W   multiplicand (mul) or divisor (div), magnitudes only
//   mode     in  1   0 = multiply, 1 = divide
//   acc_next out 2W  accumulator after the step (quotient bit slot left 0)
//   qbit     out 1   quotient bit produced by a divide step (0 for multiply)
module prv32_muldiv_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           mode,
  output logic [2*W-1:0] acc_next,
  output logic           qbit
);

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    // Remainder after the left shift can need W+1 bits before the subtract.
    shifted = acc[2*W-1:W-1];
    ge      = (shifted >= {1'b0, operand});
    diff    = shifted[W-1:0] - operand;
    qbit    = 1'b0;
    acc_next = {sum, acc[W-1:1]};
    if (mode) begin
      qbit     = ge;
      acc_next = ge ? {diff, acc[W-2:0], 1'b0} : {acc[2*W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/prv32_muldiv.sv
// rtl/prv32_muldiv.sv - iterative RV32M multiply/divide unit
//
// Purpose: 1 bit/cycle shift-add multiply and restoring divide on operand
//   magnitudes, with sign fix-up in a final FIX cycle. Optional macro
//   PRV32_MULDIV_FAST_EN sends divide-by-zero, signed overflow and MUL* with a
//   zero operand straight from accept to DONE.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request valid, accepted in IDLE or DONE
//   op          funct3 op code
//   a, b        rs1, rs2 operands, captured at accept
//   kill        flush; aborts the in-flight op, no done
//   busy        high in CALC/FIX
//   done        one-cycle pulse with valid r
//   r           result, held until the next completion
//   dz          divisor was zero, valid with done and held with r
module prv32_muldiv
  import prv32_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r,
  output logic            dz
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc, step_acc, prod;
  logic [XLEN-1:0]     opnd, sp_val, res, quot, rem;
  logic [2:0]          op_q;
  logic                sa, sb, sp, dz_pend, step_q;

  logic                accept, a_neg, b_neg, div_op, b_zero, ovf, sp_in, dz_in, fast_path;
  logic [XLEN-1:0]     sp_val_in;

  always_comb begin
    accept = start && !kill && (state == ST_IDLE || state == ST_DONE);
    a_neg  = a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    b_neg  = b[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    div_op = op[2];
    b_zero = (b == '0);
    ovf    = (op == OP_DIV || op == OP_REM) && a == XLEN_MIN_INT && b == ALL_ONES;
    dz_in  = div_op && b_zero;
    // Results known at accept; a zero MUL* operand always yields 0.
    sp_in  = dz_in || ovf || (!div_op && (a == '0 || b_zero));
    sp_val_in = '0;
    if (dz_in)    sp_val_in = op[1] ? a : ALL_ONES;
    else if (ovf) sp_val_in = op[1] ? '0 : XLEN_MIN_INT;
`ifdef PRV32_MULDIV_FAST_EN
    fast_path = sp_in;
`else
    fast_path = 1'b0;
`endif
  end

  prv32_muldiv_step #(.W(XLEN)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (op_q[2]),
    .acc_next (step_acc),
    .qbit     (step_q)
  );

  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    quot = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = quot;
      default:                      res = rem;
    endcase
    if (sp) res = sp_val;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast_path ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == CNT_W'(XLEN - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? (fast_path ? ST_DONE : ST_CALC) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= OP_MUL;
      sa      <= 1'b0;
      sb      <= 1'b0;
      sp      <= 1'b0;
      sp_val  <= '0;
      dz_pend <= 1'b0;
      r       <= '0;
      dz      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op;
        sa      <= a_neg;
        sb      <= b_neg;
        acc     <= {{XLEN{1'b0}}, (a_neg ? -a : a)};
        opnd    <= b_neg ? -b : b;
        cnt     <= '0;
        sp      <= sp_in;
        sp_val  <= sp_val_in;
        dz_pend <= dz_in;
        if (fast_path) begin
          r  <= sp_val_in;
          dz <= dz_in;
        end
      end else if (state == ST_CALC && !kill) begin
        acc <= {step_acc[2*XLEN-1:1], step_acc[0] | step_q};
        cnt <= cnt + 1'b1;
      end else if (state == ST_FIX && !kill) begin
        r  <= res;
        dz <= dz_pend;
      end
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  assign done = (state == ST_DONE);

endmodule
